// File: rtl/spec_bg_sub_readout.sv
// Background-subtracted readout: sweeps the accumulated-spectrum and background DPRAMs and streams max(spec - bg, 0).
// Optional macro SPEC_READOUT_CLEAR_EN adds clear-write strobes that zero both RAMs behind the readout.
module spec_bg_sub_readout #(
    parameter int RB_W   = 5,
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [RB_W-1:0]       i_num_rb,
    input  logic                  i_fifo_afull,
    output logic [RB_W+IDX_W-1:0] o_spec_rdaddr,
    input  logic [DATA_W-1:0]     i_spec_rddata,
    output logic [IDX_W-1:0]      o_bg_rdaddr,
    input  logic [DATA_W-1:0]     i_bg_rddata,
    output logic [DATA_W-1:0]     o_dout,
    output logic                  o_dout_valid,
    output logic [RB_W-1:0]       o_dout_rb,
    output logic [IDX_W-1:0]      o_dout_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_clamp_cnt
`ifdef SPEC_READOUT_CLEAR_EN
    ,
    output logic                  o_clr_wea,
    output logic [RB_W+IDX_W-1:0] o_clr_addr,
    output logic                  o_clr_bg_wea
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [RB_W-1:0]       r_num_rb;
    logic [RB_W-1:0]       r_rb;
    logic [IDX_W-1:0]      r_idx;
    logic [RB_W+IDX_W-1:0] r_spec_addr_hold;
    logic [IDX_W-1:0]      r_bg_addr_hold;

    logic [RD_LAT-1:0]     r_pipe_vld;
    logic [RB_W-1:0]       r_pipe_rb  [RD_LAT];
    logic [IDX_W-1:0]      r_pipe_idx [RD_LAT];

    logic                  r_dout_valid;
    logic [DATA_W-1:0]     r_dout;
    logic [RB_W-1:0]       r_dout_rb;
    logic [IDX_W-1:0]      r_dout_idx;
    logic [15:0]           r_clamp_cnt;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_pipe_empty;
    logic                  w_tok_vld;
    logic [DATA_W:0]       w_diff;
    logic                  w_neg;

    // A start is honoured only when no sweep is running (FIN already has busy low).
    assign w_accept     = i_start && ((r_state == IDLE) || (r_state == FIN));
    assign w_issue      = (r_state == ISSUE) && !i_fifo_afull;
    assign w_last_issue = w_issue && (r_rb == r_num_rb) && (&r_idx);
    assign w_pipe_empty = !(|r_pipe_vld) && !r_dout_valid;
    assign w_tok_vld    = r_pipe_vld[RD_LAT-1];

    assign w_diff = {1'b0, i_spec_rddata} - {1'b0, i_bg_rddata};
    assign w_neg  = w_diff[DATA_W];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = (i_num_rb == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                if (w_last_issue) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pipe_empty) begin
                    w_next = FIN;
                end
            end
            FIN: begin
                if (i_start) begin
                    w_next = (i_num_rb == '0) ? FIN : ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_num_rb         <= '0;
            r_rb             <= '0;
            r_idx            <= '0;
            r_spec_addr_hold <= '0;
            r_bg_addr_hold   <= '0;
        end else if (w_accept) begin
            r_num_rb <= i_num_rb;
            r_rb     <= RB_W'(1);
            r_idx    <= '0;
        end else if (w_issue) begin
            r_spec_addr_hold <= {r_rb, r_idx};
            r_bg_addr_hold   <= r_idx;
            if (&r_idx) begin
                r_idx <= '0;
                r_rb  <= r_rb + RB_W'(1);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Token/tag shift register: the last stage lines up with the RAM data of that token.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe_rb[k]  <= '0;
                r_pipe_idx[k] <= '0;
            end
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_rb[k]  <= r_pipe_rb[k-1];
                r_pipe_idx[k] <= r_pipe_idx[k-1];
            end
            r_pipe_vld[0] <= w_issue;
            r_pipe_rb[0]  <= r_rb;
            r_pipe_idx[0] <= r_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_dout_rb    <= '0;
            r_dout_idx   <= '0;
            r_clamp_cnt  <= '0;
        end else begin
            r_dout_valid <= w_tok_vld;
            if (w_tok_vld) begin
                r_dout     <= w_neg ? '0 : w_diff[DATA_W-1:0];
                r_dout_rb  <= r_pipe_rb[RD_LAT-1];
                r_dout_idx <= r_pipe_idx[RD_LAT-1];
            end
            if (w_accept) begin
                r_clamp_cnt <= '0;
            end else if (w_tok_vld && w_neg && (r_clamp_cnt != 16'hFFFF)) begin
                r_clamp_cnt <= r_clamp_cnt + 16'd1;
            end
        end
    end

    // Addresses are presented in the issue cycle itself and hold their last value otherwise.
    assign o_spec_rdaddr = w_issue ? {r_rb, r_idx} : r_spec_addr_hold;
    assign o_bg_rdaddr   = w_issue ? r_idx : r_bg_addr_hold;

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_dout_rb    = r_dout_rb;
    assign o_dout_idx   = r_dout_idx;
    assign o_busy       = (r_state == ISSUE) || (r_state == DRAIN);
    assign o_done       = (r_state == FIN);
    assign o_clamp_cnt  = r_clamp_cnt;

`ifdef SPEC_READOUT_CLEAR_EN
    // Background is shared by all bins, so it is only cleared while the last bin streams out.
    assign o_clr_wea    = r_dout_valid;
    assign o_clr_addr   = {r_dout_rb, r_dout_idx};
    assign o_clr_bg_wea = r_dout_valid && (r_dout_rb == r_num_rb);
`endif

endmodule

// File: tb/tb_spec_bg_sub_readout.sv
// Testbench for spec_bg_sub_readout: table of sweeps checked against a bin-by-bin reference model,
// plus a hand-written mid-sweep reset sequence.
`timescale 1ns/1ps
module tb_spec_bg_sub_readout;

    localparam int RB_W   = 5;
    localparam int IDX_W  = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int NPTS   = 1 << IDX_W;
    localparam int NSPEC  = 1 << (RB_W + IDX_W);

    typedef struct {
        int numRb;
        int pattern;
        int afullMode;
        bit midStart;
        int expCount;
        int expClamp;
    } sweepVec_t;

    typedef struct {
        int     rb;
        int     idx;
        longint val;
    } outRec_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic [RB_W-1:0]       numRb = '0;
    logic                  afull = 1'b0;
    logic [RB_W+IDX_W-1:0] specRdaddr;
    logic [DATA_W-1:0]     specRddata = '0;
    logic [IDX_W-1:0]      bgRdaddr;
    logic [DATA_W-1:0]     bgRddata = '0;
    logic [DATA_W-1:0]     dout;
    logic                  doutValid;
    logic [RB_W-1:0]       doutRb;
    logic [IDX_W-1:0]      doutIdx;
    logic                  busy;
    logic                  done;
    logic [15:0]           clampCnt;
`ifdef SPEC_READOUT_CLEAR_EN
    logic                  clrWea;
    logic [RB_W+IDX_W-1:0] clrAddr;
    logic                  clrBgWea;
`endif

    logic [DATA_W-1:0]     specMem [0:NSPEC-1];
    logic [DATA_W-1:0]     bgMem   [0:NPTS-1];
    logic [RB_W+IDX_W-1:0] specAddrQ = '0;
    logic [IDX_W-1:0]      bgAddrQ = '0;

    outRec_t   expQ[$];
    outRec_t   expRec;
    sweepVec_t vecs[7];

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;
    int validCount = 0;
    int validDuringAfull = 0;
    int firstValidCycle = -1;
    int doneCount = 0;
    int doneCycle = 0;
    int startCycle = 0;
    int modelClamp = 0;
    int clrWeaCount = 0;
    int clrBgCount = 0;

    spec_bg_sub_readout #(
        .RB_W  (RB_W),
        .IDX_W (IDX_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_num_rb     (numRb),
        .i_fifo_afull (afull),
        .o_spec_rdaddr(specRdaddr),
        .i_spec_rddata(specRddata),
        .o_bg_rdaddr  (bgRdaddr),
        .i_bg_rddata  (bgRddata),
        .o_dout       (dout),
        .o_dout_valid (doutValid),
        .o_dout_rb    (doutRb),
        .o_dout_idx   (doutIdx),
        .o_busy       (busy),
        .o_done       (done),
        .o_clamp_cnt  (clampCnt)
`ifdef SPEC_READOUT_CLEAR_EN
        ,
        .o_clr_wea    (clrWea),
        .o_clr_addr   (clrAddr),
        .o_clr_bg_wea (clrBgWea)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Two-cycle-latency DPRAM models: address registered, then data registered.
    always @(posedge clk) begin
        specAddrQ  <= specRdaddr;
        bgAddrQ    <= bgRdaddr;
        specRddata <= specMem[specAddrQ];
        bgRddata   <= bgMem[bgAddrQ];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Output monitor: every valid word is popped from the reference queue in order.
    always @(negedge clk) begin
        if (doutValid) begin
            validCount++;
            if (afull) validDuringAfull++;
            if (firstValidCycle < 0) firstValidCycle = cycle;
            if (expQ.size() == 0) begin
                checkOutput("unexpected dout_valid", 1, 0);
            end else begin
                expRec = expQ.pop_front();
                checkOutput("dout tag {rb,idx}", {doutRb, doutIdx}, expRec.rb * NPTS + expRec.idx);
                checkOutput("dout value", dout, expRec.val);
            end
        end
        if (done) begin
            doneCount++;
            doneCycle = cycle;
        end
`ifdef SPEC_READOUT_CLEAR_EN
        if (clrWea) begin
            clrWeaCount++;
            checkOutput("clr_wea aligned to dout_valid", doutValid, 1);
            checkOutput("clr_addr tag", clrAddr, {doutRb, doutIdx});
            specMem[clrAddr] = '0;
        end
        if (clrBgWea) begin
            clrBgCount++;
            bgMem[clrAddr[IDX_W-1:0]] = '0;
        end
`endif
    end

    task automatic loadPattern(input int pattern);
        logic [DATA_W-1:0] b;
        case (pattern)
            0: begin
                for (int a = 0; a < NSPEC; a++) specMem[a] = 32'd1000;
                for (int i = 0; i < NPTS; i++) bgMem[i] = 32'd200;
            end
            1: begin
                for (int a = 0; a < NSPEC; a++) specMem[a] = 32'd100;
                for (int i = 0; i < NPTS; i++) bgMem[i] = (i == 5) ? 32'd150 : 32'd0;
            end
            2: begin
                for (int i = 0; i < NPTS; i++) bgMem[i] = $urandom;
                bgMem[0] = '0;
                bgMem[1] = '1;
                for (int a = 0; a < NSPEC; a++) begin
                    b = bgMem[a % NPTS];
                    case ($urandom_range(0, 7))
                        0:       specMem[a] = b;
                        1:       specMem[a] = '1;
                        2:       specMem[a] = '0;
                        3:       specMem[a] = b + 32'd1;
                        default: specMem[a] = $urandom;
                    endcase
                end
            end
            default: ;
        endcase
    endtask

    // Reference: rb 1..n, idx 0..NPTS-1, value max(spec - bg, 0).
    task automatic buildExpected(input int n);
        longint s;
        longint b;
        outRec_t r;
        expQ.delete();
        modelClamp = 0;
        for (int rb = 1; rb <= n; rb++) begin
            for (int idx = 0; idx < NPTS; idx++) begin
                s = longint'(specMem[rb * NPTS + idx]);
                b = longint'(bgMem[idx]);
                r.rb  = rb;
                r.idx = idx;
                if (s >= b) begin
                    r.val = s - b;
                end else begin
                    r.val = 0;
                    if (modelClamp < 65535) modelClamp++;
                end
                expQ.push_back(r);
            end
        end
    endtask

    task automatic applyStimulus(input int n);
        validCount = 0;
        validDuringAfull = 0;
        firstValidCycle = -1;
        clrWeaCount = 0;
        clrBgCount = 0;
        afull = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        numRb = RB_W'(n);
        startCycle = cycle;
        @(posedge clk);
        #1;
        start = 1'b0;
        numRb = RB_W'($urandom);
    endtask

    task automatic runSweep(input sweepVec_t v);
        int d0;
        int waited;
        int budget;
        int delta;
        loadPattern(v.pattern);
        buildExpected(v.numRb);
        d0 = doneCount;
        budget = v.numRb * NPTS * 3 + 200;
        applyStimulus(v.numRb);
        @(negedge clk);
        if (v.numRb > 0) begin
            checkOutput("first spec_rdaddr", specRdaddr, NPTS);
            checkOutput("first bg_rdaddr", bgRdaddr, 0);
            checkOutput("busy during sweep", busy, 1);
        end
        waited = 0;
        while (doneCount == d0 && waited < budget) begin
            @(posedge clk);
            #1;
            waited++;
            case (v.afullMode)
                1:       afull = (waited >= 300 && waited < 310);
                2:       afull = ($urandom_range(0, 3) == 0);
                default: afull = 1'b0;
            endcase
            if (v.midStart && waited == 100) begin
                start = 1'b1;
                numRb = RB_W'(5);
            end else begin
                start = 1'b0;
            end
        end
        afull = 1'b0;
        start = 1'b0;
        if (doneCount == d0) checkOutput("done within cycle budget", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done pulse count", doneCount - d0, 1);
        checkOutput("output count", validCount, v.expCount);
        checkOutput("reference queue drained", expQ.size(), 0);
        checkOutput("clamp_cnt", clampCnt, (v.expClamp >= 0) ? v.expClamp : modelClamp);
        checkOutput("busy after done", busy, 0);
        if (v.numRb > 0) begin
            checkOutput("first dout latency from start", firstValidCycle - startCycle, RD_LAT + 2);
        end else begin
            delta = doneCycle - startCycle;
            checkOutput("empty sweep done within 2 cycles", (delta >= 1 && delta <= 2), 1);
        end
        if (v.afullMode == 1) begin
            checkOutput("valids during afull <= RD_LAT+1", validDuringAfull <= RD_LAT + 1, 1);
        end
`ifdef SPEC_READOUT_CLEAR_EN
        checkOutput("clr_wea pulse count", clrWeaCount, v.expCount);
        checkOutput("clr_bg_wea pulse count", clrBgCount, (v.numRb > 0) ? NPTS : 0);
`endif
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " dout"}, dout, 0);
        checkOutput({tag, " dout_valid"}, doutValid, 0);
        checkOutput({tag, " dout_rb"}, doutRb, 0);
        checkOutput({tag, " dout_idx"}, doutIdx, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " clamp_cnt"}, clampCnt, 0);
        checkOutput({tag, " spec_rdaddr"}, specRdaddr, 0);
        checkOutput({tag, " bg_rdaddr"}, bgRdaddr, 0);
    endtask

    initial begin
        int waited;
        int d0;
        sweepVec_t after;

        vecs[0] = '{2, 0, 0, 1'b0, 2048, 0};
        vecs[1] = '{1, 1, 0, 1'b0, 1024, 1};
        vecs[2] = '{1, 0, 1, 1'b0, 1024, 0};
        vecs[3] = '{0, 0, 0, 1'b0, 0, 0};
        vecs[4] = '{1, 2, 2, 1'b1, 1024, -1};
        vecs[5] = '{3, 2, 0, 1'b0, 3072, -1};
        vecs[6] = '{3, 3, 0, 1'b0, 3072, -1};

        loadPattern(0);
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            $display("[TB] sweep %0d: num_rb=%0d pattern=%0d afull=%0d", i, vecs[i].numRb, vecs[i].pattern, vecs[i].afullMode);
            runSweep(vecs[i]);
        end

        $display("[TB] mid-sweep reset");
        loadPattern(0);
        buildExpected(2);
        d0 = doneCount;
        applyStimulus(2);
        waited = 0;
        while (validCount < 500 && waited < 5000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("reached output 500", validCount, 500);
        rst = 1'b0;
        #1;
        checkAllZero("abort");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no done on abort", doneCount - d0, 0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b1;

        after = '{1, 2, 0, 1'b0, 1024, -1};
        runSweep(after);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spec_bg_sub_readout.md
Name: spec_bg_sub_readout

Overview:
- Downstream consumer of the spectrum-accumulation stage, started once all pulses of a frame have been accumulated.
- Sweeps the accumulated-spectrum DPRAM over every signal range bin and reads the matching background spectrum from DPRAM_BG.
- Subtracts background from signal with clamp at zero and streams results, tagged with range bin and FFT index, to the host-side output FIFO.
- Signal bins sit at DPRAM range-bin field 1..num_rb; background occupies DPRAM_BG addresses 0..2^IDX_W-1.

Parameters:
- RB_W, 5, range-bin field width of the DPRAM address.
- IDX_W, 10, FFT index width; points per bin = 2^IDX_W.
- DATA_W, 32, accumulated word width (unsigned).
- RD_LAT, 2, DPRAM read latency in clocks, address to data.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a readout sweep.
- num_rb  in  RB_W  number of signal range bins (0..2^RB_W-1), sampled at start.
- fifo_afull  in  1  downstream FIFO almost-full; FIFO guarantees at least RD_LAT+2 free words while asserted.
- spec_rdaddr  out  RB_W+IDX_W  DPRAM read address {rb, idx}.
- spec_rddata  in  DATA_W  DPRAM read data.
- bg_rdaddr  out  IDX_W  DPRAM_BG read address.
- bg_rddata  in  DATA_W  DPRAM_BG read data.
- dout  out  DATA_W  background-subtracted value.
- dout_valid  out  1  dout qualifier.
- dout_rb  out  RB_W  range bin of dout.
- dout_idx  out  IDX_W  FFT index of dout.
- busy  out  1  high from the start cycle until done.
- done  out  1  one-cycle pulse at end of sweep.
- clamp_cnt  out  16  number of clamped outputs this sweep, saturating at 0xFFFF.

Behaviour:
- Reset: all outputs, counters and pipeline valid bits go to 0; FSM goes to IDLE. An asserted reset mid-sweep aborts it with no done pulse.
- FSM states IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start=1 latches num_rb, sets busy, clears clamp_cnt, rb=1, idx=0. If num_rb=0, go to FIN; otherwise go to ISSUE.
  - ISSUE: each cycle with fifo_afull=0, issue spec_rdaddr={rb,idx}, bg_rdaddr=idx and push an issue token into an RD_LAT-deep valid/tag shift register.
    - idx increments; at idx=2^IDX_W-1 it wraps to 0 and rb increments.
    - After issuing {num_rb, 2^IDX_W-1}, go to DRAIN.
    - With fifo_afull=1, issue nothing and hold the counters; in-flight reads still complete.
  - DRAIN: wait until the shift register and output stage hold no valid token, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- start is ignored while busy=1.
- Datapath:
  - Issue cycle t; RAM data at t+RD_LAT; registered result at t+RD_LAT+1, so dout_valid is high at t+RD_LAT+1.
  - Tags (rb, idx) travel with the token.
  - diff = spec_rddata - bg_rddata, computed at DATA_W+1 bits signed.
  - If diff<0: dout=0 and clamp_cnt increments. Otherwise dout=diff[DATA_W-1:0].
  - Equal inputs give dout=0 with no clamp.
- Ordering: rb ascending from 1, idx ascending from 0; exactly num_rb*2^IDX_W outputs per sweep.
- Idle outputs: spec_rdaddr and bg_rdaddr hold their last value. dout holds its last value while dout_valid=0.

Optional Feature:
- Macro SPEC_READOUT_CLEAR_EN.
- Defined:
  - Adds outputs clr_wea (1), clr_addr (RB_W+IDX_W) and clr_bg_wea (1).
  - clr_wea pulses for one cycle with clr_addr equal to each token's {rb,idx}, in the same cycle that token's dout_valid is high. This zeroes the accumulator for the next frame.
  - clr_bg_wea pulses with clr_addr[IDX_W-1:0]=idx only while rb=num_rb, so the background is cleared once.
  - Both reset to 0.
- Not defined: the ports are absent and RAM contents are untouched.

Test Plan:
- Reset then start with num_rb=2, spec=1000 everywhere, bg=200, fifo_afull=0 -> 2048 outputs, each dout=800. First dout_valid 3 cycles after the first issue. Order (1,0)..(1,1023),(2,0)..(2,1023). One done pulse; busy low afterwards.
- spec=100, bg=150 at idx 5 only, num_rb=1 -> dout=0 at (1,5), clamp_cnt=1, all other outputs correct.
- fifo_afull high for 10 cycles mid-sweep -> issuing pauses, at most RD_LAT+1 dout_valid during the pause, no lost or duplicated (rb,idx), total output count still 1024*num_rb.
- start with num_rb=0 -> done pulses within 2 cycles, no dout_valid. A second start while busy=1 -> ignored, output count unchanged.
- rst asserted at output 500 -> all outputs 0 immediately with no done pulse. A new start then completes normally.
- With SPEC_READOUT_CLEAR_EN, num_rb=3 -> 3072 clr_wea pulses aligned to dout_valid, 1024 clr_bg_wea pulses during rb=3, and a second sweep outputs all zeros.
